// File: rtl/udp_tx_checksummer.sv
// udp_tx_checksummer
//   Store-and-forward UDP transmit engine. Buffers a whole datagram from the
//   layer-4 side, accumulates the UDP checksum (pseudo-header, UDP header and
//   payload) and then emits the UDP header followed by the payload towards
//   layer 3. Datagrams that overflow the buffer, have a length mismatch or
//   are aborted are discarded without any layer-3 activity.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   our_ip              source IPv4 address for the pseudo-header
//   l4_start            begins a datagram; samples dst ip, ports, length
//   l4_data_valid       payload word strobe; l4_bytes_valid (1..4, left-justified)
//   l4_data             payload word
//   l4_commit/l4_drop   end / abort of the datagram
//   busy                high whenever the engine is not idle
//   l3_start            single-cycle pulse with l3_dst_ip/l3_payload_len/l3_protocol
//   l3_data_valid       word strobe for l3_data / l3_bytes_valid
//   l3_commit           single-cycle pulse after the last word
//   overflow_drops      saturating count of datagrams lost to buffer overflow
//   length_drops        saturating count of datagrams with a length mismatch
module udp_tx_checksummer #(
  parameter int DEPTH         = 512,
  parameter bit CHECKSUM_EN   = 1'b1,
  parameter int COUNTER_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              our_ip,
  input  logic                     l4_start,
  input  logic [31:0]              l4_dst_ip,
  input  logic [15:0]              l4_src_port,
  input  logic [15:0]              l4_dst_port,
  input  logic [15:0]              l4_payload_len,
  input  logic                     l4_data_valid,
  input  logic [2:0]               l4_bytes_valid,
  input  logic [31:0]              l4_data,
  input  logic                     l4_commit,
  input  logic                     l4_drop,
  output logic                     busy,
  output logic                     l3_start,
  output logic                     l3_data_valid,
  output logic                     l3_commit,
  output logic [31:0]              l3_dst_ip,
  output logic [15:0]              l3_payload_len,
  output logic [7:0]               l3_protocol,
  output logic [2:0]               l3_bytes_valid,
  output logic [31:0]              l3_data,
  output logic [COUNTER_WIDTH-1:0] overflow_drops,
  output logic [COUNTER_WIDTH-1:0] length_drops
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_BUFFER   = 3'd1;
  localparam logic [2:0] S_FOLD_A   = 3'd2;
  localparam logic [2:0] S_FOLD_B   = 3'd3;
  localparam logic [2:0] S_HEADER_0 = 3'd4;
  localparam logic [2:0] S_HEADER_1 = 3'd5;
  localparam logic [2:0] S_BODY     = 3'd6;
  localparam logic [2:0] S_COMMIT   = 3'd7;

  logic [2:0]  state;
  logic [31:0] dst_ip;
  logic [15:0] src_port, dst_port, payload_len;
  logic [31:0] acc;
  logic [15:0] csum;
  logic [16:0] byte_count;
  logic        overflow;
  logic [AW:0] wr_cnt;
  logic [AW-1:0] rd_ptr;
  logic [16:0] words_left;
  logic [31:0] rd_data;
  logic [2:0]  rd_bv;

  logic [31:0] mem_data [DEPTH];
  logic [2:0]  mem_bv   [DEPTH];

  // Bytes beyond bytes_valid must not contribute to the checksum.
  function automatic logic [31:0] mask_word(input logic [31:0] d, input logic [2:0] bv);
    case (bv)
      3'd1:    return {d[31:24], 24'h0};
      3'd2:    return {d[31:16], 16'h0};
      3'd3:    return {d[31:8], 8'h0};
      default: return d;
    endcase
  endfunction

  // Final end-around carry and complement; zero is sent as all-ones since
  // 0x0000 on the wire means "no checksum".
  function automatic logic [15:0] finish_csum(input logic [16:0] a);
    logic [15:0] s;
    s = ~(a[15:0] + {15'b0, a[16]});
    if (!CHECKSUM_EN) return 16'h0000;
    if (s == 16'h0000) return 16'hFFFF;
    return s;
  endfunction

  function automatic logic [COUNTER_WIDTH-1:0] sat_inc(input logic [COUNTER_WIDTH-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic        full;
  logic [31:0] masked;
  logic [31:0] word_sum;
  logic [16:0] bc_next;
  logic        ovf_next;
  logic [16:0] udp_len;
  logic [31:0] seed;
  logic        mem_we;

  always_comb begin
    full     = wr_cnt[AW];
    masked   = mask_word(l4_data, l4_bytes_valid);
    word_sum = {16'b0, masked[31:16]} + {16'b0, masked[15:0]};
    bc_next  = byte_count + (l4_data_valid ? {14'b0, l4_bytes_valid} : 17'd0);
    ovf_next = overflow | (l4_data_valid & full);
    udp_len  = {1'b0, l4_payload_len} + 17'd8;
    // UDP length appears twice: once in the pseudo-header, once in the header.
    seed     = {16'b0, our_ip[31:16]} + {16'b0, our_ip[15:0]}
             + {16'b0, l4_dst_ip[31:16]} + {16'b0, l4_dst_ip[15:0]}
             + 32'h0000_0011
             + {15'b0, udp_len} + {15'b0, udp_len}
             + {16'b0, l4_src_port} + {16'b0, l4_dst_port};
    mem_we   = (state == S_BUFFER) && l4_data_valid && !full;
  end

  assign busy = (state != S_IDLE);

  // Datapath: packet fields, checksum accumulator and payload buffer.
  always_ff @(posedge clk) begin
    case (state)
      S_IDLE: begin
        if (l4_start) begin
          dst_ip      <= l4_dst_ip;
          src_port    <= l4_src_port;
          dst_port    <= l4_dst_port;
          payload_len <= l4_payload_len;
          acc         <= seed;
        end
      end
      S_BUFFER:   if (l4_data_valid) acc <= acc + word_sum;
      S_FOLD_A:   acc <= {15'b0, {1'b0, acc[15:0]} + {1'b0, acc[31:16]}};
      S_FOLD_B:   csum <= finish_csum(acc[16:0]);
      // Registered read: the word is fetched one cycle before it is sent.
      S_HEADER_1, S_BODY: begin
        rd_data <= mem_data[rd_ptr];
        rd_bv   <= mem_bv[rd_ptr];
      end
      default: ;
    endcase
    if (mem_we) begin
      mem_data[wr_cnt[AW-1:0]] <= l4_data;
      mem_bv[wr_cnt[AW-1:0]]   <= l4_bytes_valid;
    end
  end

  // Control: state machine, buffer pointers, drop counters, layer-3 outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      byte_count     <= '0;
      overflow       <= 1'b0;
      wr_cnt         <= '0;
      rd_ptr         <= '0;
      words_left     <= '0;
      overflow_drops <= '0;
      length_drops   <= '0;
      l3_start       <= 1'b0;
      l3_data_valid  <= 1'b0;
      l3_commit      <= 1'b0;
      l3_dst_ip      <= '0;
      l3_payload_len <= '0;
      l3_protocol    <= 8'h11;
      l3_bytes_valid <= '0;
      l3_data        <= '0;
    end else begin
      l3_start      <= 1'b0;
      l3_data_valid <= 1'b0;
      l3_commit     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (l4_start) begin
            state      <= S_BUFFER;
            byte_count <= '0;
            overflow   <= 1'b0;
            wr_cnt     <= '0;
            rd_ptr     <= '0;
            words_left <= ({1'b0, l4_payload_len} + 17'd3) >> 2;
          end
        end
        S_BUFFER: begin
          if (l4_data_valid) begin
            byte_count <= bc_next;
            if (full) overflow <= 1'b1;
            else      wr_cnt   <= wr_cnt + 1'b1;
          end
          if (l4_drop) begin
            state  <= S_IDLE;
            wr_cnt <= '0;
          end else if (l4_commit) begin
            if (ovf_next) begin
              state          <= S_IDLE;
              wr_cnt         <= '0;
              overflow_drops <= sat_inc(overflow_drops);
            end else if (bc_next != {1'b0, payload_len}) begin
              state        <= S_IDLE;
              wr_cnt       <= '0;
              length_drops <= sat_inc(length_drops);
            end else begin
              state <= S_FOLD_A;
            end
          end
        end
        S_FOLD_A: state <= S_FOLD_B;
        S_FOLD_B: begin
          l3_start       <= 1'b1;
          l3_dst_ip      <= dst_ip;
          l3_payload_len <= payload_len + 16'd8;
          state          <= S_HEADER_0;
        end
        S_HEADER_0: begin
          l3_data_valid  <= 1'b1;
          l3_data        <= {src_port, dst_port};
          l3_bytes_valid <= 3'd4;
          state          <= S_HEADER_1;
        end
        S_HEADER_1: begin
          l3_data_valid  <= 1'b1;
          l3_data        <= {payload_len + 16'd8, csum};
          l3_bytes_valid <= 3'd4;
          rd_ptr         <= rd_ptr + 1'b1;
          state          <= (payload_len == 16'd0) ? S_COMMIT : S_BODY;
        end
        S_BODY: begin
          l3_data_valid  <= 1'b1;
          l3_data        <= rd_data;
          l3_bytes_valid <= rd_bv;
          rd_ptr         <= rd_ptr + 1'b1;
          words_left     <= words_left - 17'd1;
          if (words_left == 17'd1) state <= S_COMMIT;
        end
        S_COMMIT: begin
          l3_commit <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_checksummer.sv
module tb_udp_tx_checksummer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] our_ip;
  logic        l4_start, l4_data_valid, l4_commit, l4_drop;
  logic [31:0] l4_dst_ip, l4_data;
  logic [15:0] l4_src_port, l4_dst_port, l4_payload_len;
  logic [2:0]  l4_bytes_valid;

  logic        busy, l3_start, l3_data_valid, l3_commit;
  logic [31:0] l3_dst_ip, l3_data;
  logic [15:0] l3_payload_len;
  logic [7:0]  l3_protocol;
  logic [2:0]  l3_bytes_valid;
  logic [15:0] overflow_drops, length_drops;

  logic        nc_busy, nc_l3_start, nc_l3_data_valid, nc_l3_commit;
  logic [31:0] nc_l3_dst_ip, nc_l3_data;
  logic [15:0] nc_l3_payload_len;
  logic [7:0]  nc_l3_protocol;
  logic [2:0]  nc_l3_bytes_valid;
  logic [1:0]  nc_overflow_drops, nc_length_drops;

  always #5 clk = ~clk;

  udp_tx_checksummer #(.DEPTH(4), .CHECKSUM_EN(1'b1), .COUNTER_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .our_ip(our_ip),
    .l4_start(l4_start), .l4_dst_ip(l4_dst_ip), .l4_src_port(l4_src_port),
    .l4_dst_port(l4_dst_port), .l4_payload_len(l4_payload_len),
    .l4_data_valid(l4_data_valid), .l4_bytes_valid(l4_bytes_valid), .l4_data(l4_data),
    .l4_commit(l4_commit), .l4_drop(l4_drop), .busy(busy),
    .l3_start(l3_start), .l3_data_valid(l3_data_valid), .l3_commit(l3_commit),
    .l3_dst_ip(l3_dst_ip), .l3_payload_len(l3_payload_len), .l3_protocol(l3_protocol),
    .l3_bytes_valid(l3_bytes_valid), .l3_data(l3_data),
    .overflow_drops(overflow_drops), .length_drops(length_drops)
  );

  udp_tx_checksummer #(.DEPTH(4), .CHECKSUM_EN(1'b0), .COUNTER_WIDTH(2)) dut_nc (
    .clk(clk), .rst_n(rst_n), .our_ip(our_ip),
    .l4_start(l4_start), .l4_dst_ip(l4_dst_ip), .l4_src_port(l4_src_port),
    .l4_dst_port(l4_dst_port), .l4_payload_len(l4_payload_len),
    .l4_data_valid(l4_data_valid), .l4_bytes_valid(l4_bytes_valid), .l4_data(l4_data),
    .l4_commit(l4_commit), .l4_drop(l4_drop), .busy(nc_busy),
    .l3_start(nc_l3_start), .l3_data_valid(nc_l3_data_valid), .l3_commit(nc_l3_commit),
    .l3_dst_ip(nc_l3_dst_ip), .l3_payload_len(nc_l3_payload_len), .l3_protocol(nc_l3_protocol),
    .l3_bytes_valid(nc_l3_bytes_valid), .l3_data(nc_l3_data),
    .overflow_drops(nc_overflow_drops), .length_drops(nc_length_drops)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Layer-3 monitor, sampled on the falling edge.
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [31:0] q_data[$];
  logic [2:0]  q_bv[$];
  logic [31:0] q_nc[$];
  int          n_start = 0, n_commit = 0, start_cyc = 0, commit_cyc = 0;
  logic [31:0] cap_ip;
  logic [15:0] cap_len;

  always @(negedge clk) begin
    if (l3_start) begin
      n_start++;
      start_cyc = cyc;
      cap_ip    = l3_dst_ip;
      cap_len   = l3_payload_len;
    end
    if (l3_data_valid) begin
      q_data.push_back(l3_data);
      q_bv.push_back(l3_bytes_valid);
    end
    if (nc_l3_data_valid) q_nc.push_back(nc_l3_data);
    if (l3_commit) begin
      n_commit++;
      commit_cyc = cyc;
    end
  end

  logic [31:0] pay [8];
  logic [2:0]  pbv [8];
  int          commit_edge;

  function automatic logic [31:0] bmask(input logic [2:0] bv);
    case (bv)
      3'd1:    return 32'hFF00_0000;
      3'd2:    return 32'hFFFF_0000;
      3'd3:    return 32'hFFFF_FF00;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // end_kind: 0 commit on last word, 1 separate drop after the words,
  // 2 drop together with commit on last word. Called at #1 after a posedge.
  task automatic send(input logic [15:0] len, input int nw, input int end_kind);
    q_data.delete(); q_bv.delete(); q_nc.delete();
    l4_start = 1'b1; l4_dst_ip = 32'h0A00_0002;
    l4_src_port = 16'h1234; l4_dst_port = 16'h5678; l4_payload_len = len;
    @(posedge clk); #1;
    l4_start = 1'b0;
    if (nw == 0) begin
      l4_commit = 1'b1;
      l4_drop   = (end_kind == 2);
      @(posedge clk); #1;
    end
    for (int i = 0; i < nw; i++) begin
      l4_data_valid  = 1'b1;
      l4_data        = pay[i];
      l4_bytes_valid = pbv[i];
      l4_commit      = (i == nw - 1) && (end_kind != 1);
      l4_drop        = (i == nw - 1) && (end_kind == 2);
      @(posedge clk); #1;
    end
    l4_data_valid = 1'b0; l4_commit = 1'b0; l4_drop = 1'b0; l4_data = '0;
    if (end_kind == 1) begin
      l4_drop = 1'b1;
      @(posedge clk); #1;
      l4_drop = 1'b0;
    end
    commit_edge = cyc;
  endtask

  task automatic expect_pkt(input string tag, input logic [15:0] ulen,
                            input logic [31:0] hdr1, input logic [31:0] nc_hdr1, input int nbody);
    int base_c = n_commit;
    int base_s = n_start;
    int t = 0;
    while (n_commit == base_c && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    chk({tag, " commit_count"}, n_commit - base_c, 1);
    chk({tag, " start_count"}, n_start - base_s, 1);
    chk({tag, " start_latency"}, start_cyc - commit_edge, 2);
    chk({tag, " start_to_commit"}, commit_cyc - start_cyc, 3 + nbody);
    chk({tag, " dst_ip"}, cap_ip, 32'h0A00_0002);
    chk({tag, " l3_len"}, cap_len, ulen);
    chk({tag, " word_count"}, q_data.size(), 2 + nbody);
    if (q_data.size() == 2 + nbody) begin
      chk({tag, " hdr0"}, q_data[0], 32'h1234_5678);
      chk({tag, " hdr1"}, q_data[1], hdr1);
      chk({tag, " hdr_bv"}, {q_bv[0], q_bv[1]}, {3'd4, 3'd4});
      for (int i = 0; i < nbody; i++) begin
        chk($sformatf("%s body%0d", tag, i), q_data[2+i] & bmask(pbv[i]), pay[i] & bmask(pbv[i]));
        chk($sformatf("%s bv%0d", tag, i), q_bv[2+i], pbv[i]);
      end
    end
    if (q_nc.size() >= 2) chk({tag, " nocsum_hdr1"}, q_nc[1], nc_hdr1);
    else                  chk({tag, " nocsum_words"}, q_nc.size(), 2);
    chk({tag, " busy_after"}, busy, 1'b0);
  endtask

  task automatic expect_none(input string tag, input int base_s, input int base_c);
    repeat (12) @(posedge clk);
    #1;
    chk({tag, " no_start"}, n_start - base_s, 0);
    chk({tag, " no_commit"}, n_commit - base_c, 0);
    chk({tag, " no_data"}, q_data.size(), 0);
  endtask

  initial begin
    int s0, c0, t;
    rst_n = 1'b0; our_ip = 32'h0A00_0001;
    l4_start = 0; l4_data_valid = 0; l4_commit = 0; l4_drop = 0;
    l4_dst_ip = '0; l4_src_port = '0; l4_dst_port = '0; l4_payload_len = '0;
    l4_bytes_valid = '0; l4_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst protocol", l3_protocol, 8'h11);
    chk("rst busy", busy, 1'b0);
    chk("rst strobes", {l3_start, l3_data_valid, l3_commit}, 3'b000);
    chk("rst data", l3_data, 32'h0);
    chk("rst counters", {overflow_drops, length_drops}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 4-byte payload, hand checksum 0xE589.
    pay[0] = 32'hDEAD_BEEF; pbv[0] = 3'd4;
    send(16'd4, 1, 0);
    expect_pkt("t1", 16'd12, 32'h000C_E589, 32'h000C_0000, 1);

    // 5-byte payload, last word one valid byte with junk below it.
    pay[1] = 32'hAA11_2233; pbv[1] = 3'd1;
    send(16'd5, 2, 0);
    expect_pkt("t2", 16'd13, 32'h000D_3B87, 32'h000D_0000, 2);

    // Exactly fills the 4-word buffer.
    for (int i = 0; i < 4; i++) begin pay[i] = i + 1; pbv[i] = 3'd4; end
    send(16'd16, 4, 0);
    expect_pkt("full", 16'd24, 32'h0018_8305, 32'h0018_0000, 4);

    // 20 bytes into a 4-word buffer.
    for (int i = 0; i < 5; i++) begin pay[i] = 32'h1111_1111 * (i + 1); pbv[i] = 3'd4; end
    s0 = n_start; c0 = n_commit;
    send(16'd20, 5, 0);
    chk("ovf busy_low", busy, 1'b0);
    expect_none("ovf", s0, c0);
    chk("ovf overflow_drops", overflow_drops, 16'd1);
    chk("ovf length_drops", length_drops, 16'd0);

    // Declared 8 bytes, 12 sent.
    s0 = n_start; c0 = n_commit;
    send(16'd8, 3, 0);
    expect_none("len", s0, c0);
    chk("len length_drops", length_drops, 16'd1);
    pay[0] = 32'hDEAD_BEEF; pbv[0] = 3'd4;
    send(16'd4, 1, 0);
    expect_pkt("after_len", 16'd12, 32'h000C_E589, 32'h000C_0000, 1);

    // Abort after two words, then start again immediately.
    s0 = n_start;
    pay[0] = 32'hCAFE_0001; pay[1] = 32'hCAFE_0002; pbv[0] = 3'd4; pbv[1] = 3'd4;
    send(16'd8, 2, 1);
    pay[0] = 32'h0102_0304; pbv[0] = 3'd4;
    send(16'd4, 1, 0);
    expect_pkt("t5", 16'd12, 32'h000C_7F21, 32'h000C_0000, 1);
    chk("t5 only_second", n_start - s0, 1);

    // Drop coincident with commit.
    s0 = n_start; c0 = n_commit;
    send(16'd4, 1, 2);
    expect_none("drop_commit", s0, c0);
    chk("drop counters", {overflow_drops, length_drops}, {16'd1, 16'd1});

    // Zero-length datagram.
    send(16'd0, 0, 0);
    expect_pkt("zero", 16'd8, 32'h0008_832F, 32'h0008_0000, 0);

    // Reset in the middle of the body.
    for (int i = 0; i < 4; i++) begin pay[i] = i + 1; pbv[i] = 3'd4; end
    c0 = n_commit;
    send(16'd16, 4, 0);
    t = 0;
    while (q_data.size() < 3 && t < 40) begin @(negedge clk); t++; end
    chk("rst_mid reached_body", q_data.size() >= 3, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid strobes", {l3_start, l3_data_valid, l3_commit, busy}, 4'b0000);
    chk("rst_mid data", {l3_data, l3_bytes_valid}, 35'h0);
    chk("rst_mid hdr", {l3_dst_ip, l3_payload_len}, 48'h0);
    chk("rst_mid protocol", l3_protocol, 8'h11);
    chk("rst_mid counters", {overflow_drops, length_drops}, 32'h0);
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_mid no_commit", n_commit - c0, 0);
    pay[0] = 32'hDEAD_BEEF; pbv[0] = 3'd4;
    send(16'd4, 1, 0);
    expect_pkt("after_rst", 16'd12, 32'h000C_E589, 32'h000C_0000, 1);

    // Four length drops: saturates the 2-bit counters of the second instance.
    for (int k = 0; k < 4; k++) begin
      send(16'd1, 0, 0);
      @(posedge clk); #1;
    end
    chk("sat length_drops", length_drops, 16'd4);
    chk("sat nc_length_drops", nc_length_drops, 2'd3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
